fc_mac_sequencer: RTL and testbench

Sequential controller for the fully-connected stage of the CNN. It streams the flattened output feature map and the fully-connected weights from their buffers `LANES` elements per cycle and accumulates the products. It adds the bias exactly once, then saturates the accumulator to `DATA_WIDTH` and reports the result with a start/done handshake. It sits between the flatten buffer, the weight ROM and the classifier output register, and replaces a single-cycle 432-wide combinational reduction with a time-multiplexed MAC array.

---
 rtl/fc_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_fc_mac_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_mac_sequencer.sv
// Time-multiplexed MAC controller for the fully-connected layer: streams LANES
// feature/weight pairs per beat, accumulates, adds bias once, then saturates.
module fc_mac_sequencer #(
    parameter int FLATTENED_LENGTH          = 432,
    parameter int DATA_WIDTH                = 8,
    parameter int BIAS_DATA_WIDTH           = 32,
    parameter int FULLYCONNECTED_DATA_WIDTH = 32,
    parameter int LANES                     = 4,
    localparam int BEATS      = (FLATTENED_LENGTH + LANES - 1) / LANES,
    localparam int ADDR_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        fullyconnect_start,
    input  logic signed [BIAS_DATA_WIDTH-1:0]           bias,
    output logic                                        busy,
    output logic                                        rd_en,
    output logic        [ADDR_WIDTH-1:0]                rd_addr,
    input  logic        [LANES*DATA_WIDTH-1:0]          fmap_rd_data,
    input  logic        [LANES*DATA_WIDTH-1:0]          weight_rd_data,
    output logic signed [FULLYCONNECTED_DATA_WIDTH-1:0] fc_sum,
    output logic signed [DATA_WIDTH-1:0]                fullyconnected_output,
    output logic                                        done
);

    localparam int FCW = FULLYCONNECTED_DATA_WIDTH;

    localparam logic signed [FCW-1:0] SAT_MAX =
        {{(FCW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [FCW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        BIAS,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                         start_accept;
    logic        [ADDR_WIDTH-1:0] beat_cnt;
    logic                         issued_q;
    logic        [ADDR_WIDTH-1:0] issued_beat_q;
    logic signed [FCW-1:0]        acc;
    logic signed [BIAS_DATA_WIDTH-1:0] bias_q;
    logic signed [FCW-1:0]        bias_ext;
    logic signed [FCW-1:0]        sum_next;
    logic signed [FCW-1:0]        beat_sum;
    logic signed [FCW-1:0]        lane_fmap;
    logic signed [FCW-1:0]        lane_weight;
    logic signed [DATA_WIDTH-1:0] sat_next;

    assign start_accept = fullyconnect_start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fullyconnect_start) state_d = FETCH;
            FETCH:   if (beat_cnt == LAST_BEAT) state_d = DRAIN;
            DRAIN:   state_d = BIAS;
            BIAS:    state_d = DONE;
            DONE:    state_d = fullyconnect_start ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == FETCH) || (state_q == DRAIN) || (state_q == BIAS);
        rd_en   = (state_q == FETCH);
        rd_addr = (state_q == FETCH) ? beat_cnt : '0;
        done    = (state_q == DONE);
    end

    // Lanes past the end of the flattened map are masked so stale or junk
    // buffer contents in a partial final beat never reach the accumulator.
    always_comb begin
        beat_sum    = '0;
        lane_fmap   = '0;
        lane_weight = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_fmap   = FCW'($signed(fmap_rd_data[j*DATA_WIDTH +: DATA_WIDTH]));
            lane_weight = FCW'($signed(weight_rd_data[j*DATA_WIDTH +: DATA_WIDTH]));
            if ((int'(issued_beat_q) * LANES + j) < FLATTENED_LENGTH) begin
                beat_sum = beat_sum + lane_fmap * lane_weight;
            end
        end
    end

    always_comb begin
        bias_ext = FCW'(bias_q);
        sum_next = acc + bias_ext;
        if (sum_next > SAT_MAX) begin
            sat_next = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum_next < SAT_MIN) begin
            sat_next = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_next = sum_next[DATA_WIDTH-1:0];
        end
    end

    // Buffer data lags rd_en by one cycle, so the beat index travels along
    // with a valid flag and the accumulate happens on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt              <= '0;
            issued_q              <= 1'b0;
            issued_beat_q         <= '0;
            acc                   <= '0;
            bias_q                <= '0;
            fc_sum                <= '0;
            fullyconnected_output <= '0;
        end else begin
            issued_q      <= (state_q == FETCH);
            issued_beat_q <= beat_cnt;
            if (issued_q) begin
                acc <= acc + beat_sum;
            end
            if (state_q == FETCH) begin
                beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
            end
            if (start_accept) begin
                acc      <= '0;
                beat_cnt <= '0;
                bias_q   <= bias;
            end
            if (state_q == BIAS) begin
                fc_sum                <= sum_next;
                fullyconnected_output <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Randomised scoreboard bench for fc_mac_sequencer with a short, non-multiple
// flattened length so partial-beat masking and saturation are both exercised.
module tb_fc_mac_sequencer;

    localparam int FL    = 10;
    localparam int DW    = 8;
    localparam int BW    = 32;
    localparam int FCW   = 32;
    localparam int LANES = 4;
    localparam int BEATS = (FL + LANES - 1) / LANES;
    localparam int AW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                    clk;
    logic                    reset;
    logic                    fullyconnect_start;
    logic signed [BW-1:0]    bias;
    logic                    busy;
    logic                    rd_en;
    logic        [AW-1:0]    rd_addr;
    logic        [LANES*DW-1:0] fmap_rd_data;
    logic        [LANES*DW-1:0] weight_rd_data;
    logic signed [FCW-1:0]   fc_sum;
    logic signed [DW-1:0]    fullyconnected_output;
    logic                    done;

    typedef struct {
        int start_cyc;
        int done_cyc;
        int sum;
        int out;
    } exp_t;

    exp_t exp_q[$];

    logic signed [DW-1:0] fmap_mem [FL];
    logic signed [DW-1:0] w_mem    [FL];
    logic        [DW-1:0] junk_val;
    bit                   junk_rand;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int exp_hold = 0;
    int exp_out_hold = 0;

    fc_mac_sequencer #(
        .FLATTENED_LENGTH          (FL),
        .DATA_WIDTH                (DW),
        .BIAS_DATA_WIDTH           (BW),
        .FULLYCONNECTED_DATA_WIDTH (FCW),
        .LANES                     (LANES)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .fullyconnect_start    (fullyconnect_start),
        .bias                  (bias),
        .busy                  (busy),
        .rd_en                 (rd_en),
        .rd_addr               (rd_addr),
        .fmap_rd_data          (fmap_rd_data),
        .weight_rd_data        (weight_rd_data),
        .fc_sum                (fc_sum),
        .fullyconnected_output (fullyconnected_output),
        .done                  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous buffers: one-cycle read latency, junk beyond the map end
    // and random noise whenever no read is issued.
    always @(posedge clk) begin
        int idx;
        logic [DW-1:0] fv, wv;
        for (int j = 0; j < LANES; j++) begin
            idx = int'(rd_addr) * LANES + j;
            if (rd_en && idx < FL) begin
                fv = fmap_mem[idx];
                wv = w_mem[idx];
            end else if (rd_en) begin
                fv = junk_rand ? DW'($urandom) : junk_val;
                wv = junk_rand ? DW'($urandom) : junk_val;
            end else begin
                fv = DW'($urandom);
                wv = DW'($urandom);
            end
            fmap_rd_data[j*DW +: DW]   <= fv;
            weight_rd_data[j*DW +: DW] <= wv;
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic int model_sum(input int b);
        int s;
        s = b;
        for (int i = 0; i < FL; i++) begin
            s += int'(fmap_mem[i]) * int'(w_mem[i]);
        end
        return s;
    endfunction

    function automatic int model_sat(input int s);
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    // Called at a negedge; the start is sampled on the next rising edge.
    task automatic applyStimulus(input int b, input bit expect_accept);
        exp_t e;
        fullyconnect_start = 1'b1;
        bias = b;
        if (expect_accept) begin
            e.start_cyc = cyc;
            e.done_cyc  = cyc + BEATS + 3;
            e.sum       = model_sum(b);
            e.out       = model_sat(e.sum);
            exp_q.push_back(e);
        end
        @(negedge clk);
        fullyconnect_start = 1'b0;
        bias = $urandom;
    endtask

    task automatic fill_const(input int f, input int w);
        for (int i = 0; i < FL; i++) begin
            fmap_mem[i] = DW'(f);
            w_mem[i]    = DW'(w);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < FL; i++) begin
            fmap_mem[i] = DW'($urandom);
            w_mem[i]    = DW'($urandom);
        end
    endtask

    task automatic wait_idle();
        repeat (BEATS + 4) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_rd_en"}, rd_en, 0);
        checkOutput({tag, "_rd_addr"}, rd_addr, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_fc_sum"}, fc_sum, 0);
        checkOutput({tag, "_output"}, fullyconnected_output, 0);
    endtask

    // Monitor: derives the expected handshake timeline from the pending runs
    // and retires a run when its done cycle arrives.
    always begin
        bit has, e_busy, e_rd, e_done;
        int s, d, e_addr;
        @(posedge clk);
        #1;
        if (!reset) begin
            has    = exp_q.size() > 0;
            s      = has ? exp_q[0].start_cyc : 0;
            d      = has ? exp_q[0].done_cyc : 0;
            e_busy = has && cyc > s && cyc < d;
            e_rd   = has && cyc > s && cyc <= s + BEATS;
            e_addr = e_rd ? cyc - s - 1 : 0;
            e_done = has && cyc == d;
            if (e_done) begin
                exp_hold     = exp_q[0].sum;
                exp_out_hold = exp_q[0].out;
                void'(exp_q.pop_front());
            end
            checkOutput("busy", busy, e_busy);
            checkOutput("rd_en", rd_en, e_rd);
            checkOutput("rd_addr", rd_addr, e_addr);
            checkOutput("done", done, e_done);
            checkOutput("fc_sum", fc_sum, exp_hold);
            checkOutput("output", fullyconnected_output, exp_out_hold);
        end
    end

    initial begin
        int b;
        reset = 1'b1;
        fullyconnect_start = 1'($urandom);
        bias = $urandom;
        junk_rand = 1'b0;
        junk_val = 8'h7F;
        fill_const(0, 0);
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        fullyconnect_start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed runs");
        fill_const(1, 1);
        applyStimulus(0, 1);
        wait_idle();
        applyStimulus(5, 1);
        wait_idle();
        fill_const(127, 127);
        applyStimulus(0, 1);
        wait_idle();
        fill_const(127, -128);
        applyStimulus(0, 1);
        wait_idle();
        fill_const(127, 127);
        applyStimulus(32'h7FFF_FFF0, 1);
        wait_idle();
        fill_const(0, 0);
        applyStimulus(127, 1);
        wait_idle();
        applyStimulus(128, 1);
        wait_idle();
        applyStimulus(-128, 1);
        wait_idle();
        applyStimulus(-129, 1);
        wait_idle();

        $display("[TB] ignored starts and back-to-back runs");
        junk_rand = 1'b1;
        fill_random();
        applyStimulus(17, 1);
        applyStimulus(-999, 0);
        repeat (BEATS + 3) @(negedge clk);
        applyStimulus(-3, 1);
        repeat (BEATS) @(negedge clk);
        applyStimulus(4444, 0);
        wait_idle();
        applyStimulus(100, 1);
        repeat (BEATS + 2) @(negedge clk);
        applyStimulus(-100, 1);
        repeat (BEATS + 2) @(negedge clk);
        applyStimulus(7, 1);
        wait_idle();

        $display("[TB] mid-run reset");
        applyStimulus(33, 1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        exp_hold = 0;
        exp_out_hold = 0;
        repeat (2) @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(-20, 1);
        wait_idle();

        $display("[TB] random runs");
        for (int r = 0; r < 30; r++) begin
            fill_random();
            if ($urandom_range(0, 1) == 1) b = int'($urandom_range(0, 800)) - 400;
            else b = $urandom;
            applyStimulus(b, 1);
            if ($urandom_range(0, 2) == 0) repeat (BEATS + 2) @(negedge clk);
            else repeat (BEATS + 2 + $urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();

        checkOutput("pending_runs", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
